// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the hazard controller slice: defaults, scoreboard entry, multi-cycle state.
package cpu_pkg;

    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned DEPTH_DEF  = 3;
    // Widest register address an entry can hold; narrower addresses are zero-extended into it.
    localparam int unsigned RD_W_MAX   = 8;

    typedef logic [RD_W_MAX-1:0] rd_t;

    // One tracked in-flight instruction; valid only when it really writes a non-zero rd.
    typedef struct packed {
        logic valid;
        rd_t  rd;
        logic is_load;
        logic is_mc;
    } sb_entry_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    // A used, non-zero source matches a valid entry writing the same register.
    function automatic logic src_match(input sb_entry_t e, input rd_t rs, input logic used);
        return used && e.valid && (rs != '0) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX hazard-control bundle between the pipeline (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = cpu_pkg::REG_AW_DEF,
    parameter int unsigned SEL_W  = $clog2(cpu_pkg::DEPTH_DEF)
);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_wb_en;
    logic              id_is_load;
    logic              id_is_mc;
    logic              ex_mc_done;
    logic              br_taken;

    logic              stall_if;
    logic              stall_id;
    logic              flush_id;
    logic              bubble_ex;
    logic [SEL_W-1:0]  fwd_rs1_sel;
    logic [SEL_W-1:0]  fwd_rs2_sel;
    logic [31:0]       stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_wb_en, id_is_load, id_is_mc, ex_mc_done, br_taken,
        input  stall_if, stall_id, flush_id, bubble_ex, fwd_rs1_sel, fwd_rs2_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_wb_en, id_is_load, id_is_mc, ex_mc_done, br_taken,
        output stall_if, stall_id, flush_id, bubble_ex, fwd_rs1_sel, fwd_rs2_sel, stall_cnt
    );

endinterface

// File: rtl/hz_scoreboard.sv
// Shift/hold register tracking destinations of the post-ID stages E[0]=EX .. E[DEPTH-1]=WB.
module hz_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_e0,
    input  logic                  issue,
    input  sb_entry_t             id_entry,
    output sb_entry_t [DEPTH-1:0] entries
);

    sb_entry_t [DEPTH-1:0] sb_q;
    sb_entry_t [DEPTH-1:0] sb_d;

    // Next contents: age every stage by one, then E[0] either holds (multi-cycle) or takes ID/bubble.
    always_comb begin
        // NOTE: sb_d gets a full default first so no path through this block can infer a latch.
        sb_d = sb_q;
        for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
            sb_d[k] = sb_q[k-1];
        end
        if (hold_e0) begin
            sb_d[0] = sb_q[0];
            sb_d[1] = '0;
        end else if (issue) begin
            sb_d[0] = id_entry;
        end else begin
            sb_d[0] = '0;
        end
    end

    // Scoreboard register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        // NOTE: the whole register is cleared, not just the valid bits, so no X ever reaches the rd compares.
        if (!rst) begin
            // NOTE: sequential state always uses non-blocking assignment so every stage samples pre-edge values.
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign entries = sb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: load-use stall, multi-cycle EX hold, branch flush and registered forward selects.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned SEL_W  = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    sb_entry_t [DEPTH-1:0] sb;
    sb_entry_t             id_entry;
    rd_t                   rs1_x;
    rd_t                   rs2_x;
    rd_t                   rd_x;
    mc_state_t             state_q;
    mc_state_t             state_d;
    logic                  mc_start;
    logic                  mc_hold;
    logic                  load_use;
    logic                  flush;
    logic                  stall_raw;
    logic                  issue;
    logic                  stall_out;
    logic                  bubble_out;
    logic [SEL_W-1:0]      sel1_d;
    logic [SEL_W-1:0]      sel2_d;
    logic [SEL_W-1:0]      sel1_q;
    logic [SEL_W-1:0]      sel2_q;
    logic [31:0]           stall_cnt_q;
    logic                  unused_sb;

    // Widen ID addresses to entry width and build the entry this instruction would occupy in E[0].
    always_comb begin
        rs1_x = '0;
        rs2_x = '0;
        rd_x  = '0;
        rs1_x[REG_AW-1:0] = hz.id_rs1;
        rs2_x[REG_AW-1:0] = hz.id_rs2;
        rd_x[REG_AW-1:0]  = hz.id_rd;
        id_entry          = '0;
        id_entry.valid    = hz.id_wb_en && (rd_x != '0);
        id_entry.rd       = rd_x;
        id_entry.is_load  = hz.id_is_load;
        id_entry.is_mc    = hz.id_is_mc;
    end

    hz_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .hold_e0  (mc_hold),
        .issue    (issue),
        .id_entry (id_entry),
        .entries  (sb)
    );

    // Entries beyond what the hazard terms inspect (e.g. the WB stage) are only carried along.
    assign unused_sb = ^sb;

    // A multi-cycle op sitting in EX that is not finishing this cycle.
    assign mc_start = sb[0].valid && sb[0].is_mc && !hz.ex_mc_done;

    // Multi-cycle state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Multi-cycle next state: enter on an unfinished mc op in EX, leave on done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mc_start)      state_d = MC_BUSY;
            MC_BUSY: if (hz.ex_mc_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multi-cycle output: keep the op in EX for every cycle it has not reported done.
    always_comb begin
        mc_hold = 1'b0;
        case (state_q)
            IDLE:    mc_hold = mc_start;
            MC_BUSY: mc_hold = !hz.ex_mc_done;
            default: mc_hold = 1'b0;
        endcase
    end

    // Load in EX whose data is only ready from E[2]: the dependent ID instruction must wait one cycle.
    assign load_use = hz.id_valid && sb[0].valid && sb[0].is_load &&
                      (src_match(sb[0], rs1_x, hz.id_rs1_used) ||
                       src_match(sb[0], rs2_x, hz.id_rs2_used));

    assign flush      = hz.br_taken;
    assign stall_raw  = hz.id_valid && (mc_hold || load_use);
    assign issue      = hz.id_valid && !stall_raw && !flush && !mc_hold;
    assign stall_out  = rst && stall_raw && !flush;
    assign bubble_out = rst && (flush || (load_use && !mc_hold));

    assign hz.stall_if  = stall_out;
    assign hz.stall_id  = stall_out;
    assign hz.flush_id  = rst && flush;
    assign hz.bubble_ex = bubble_out;

    // Forward selects for the ID instruction: scan oldest to youngest so the youngest match wins.
    always_comb begin
        sel1_d = '0;
        sel2_d = '0;
        for (int j = int'(DEPTH) - 2; j >= 0; j--) begin
            if (src_match(sb[j], rs1_x, hz.id_rs1_used)) sel1_d = SEL_W'(j + 1);
            if (src_match(sb[j], rs2_x, hz.id_rs2_used)) sel2_d = SEL_W'(j + 1);
        end
    end

    // Selects follow the instruction into EX; they hold while a multi-cycle op occupies EX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel1_q <= '0;
            sel2_q <= '0;
        end else if (mc_hold) begin
            sel1_q <= sel1_q;
            sel2_q <= sel2_q;
        end else if (issue) begin
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
        end else begin
            sel1_q <= '0;
            sel2_q <= '0;
        end
    end

    // Saturating count of cycles in which ID was stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_out && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    // Registered outputs are also forced low while reset is held.
    assign hz.fwd_rs1_sel = rst ? sel1_q : '0;
    assign hz.fwd_rs2_sel = rst ? sel2_q : '0;
    assign hz.stall_cnt   = rst ? stall_cnt_q : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DEPTH=3): forwarding, load-use, multi-cycle, flush, x0, reset.
module tb_pipe_hazard_ctrl;
    import cpu_pkg::*;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned SEL_W  = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .SEL_W(SEL_W)) hz ();

    pipe_hazard_ctrl #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A taken branch while a multi-cycle op is busy is outside the protocol.
    always @(posedge clk) begin
        if (rst && dut.state_q == MC_BUSY) begin
            assert (!hz.br_taken) else $error("br_taken asserted while multi-cycle op busy");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] ctl();
        return {hz.stall_if, hz.stall_id, hz.flush_id, hz.bubble_ex};
    endfunction

    function automatic logic [3:0] sels();
        return {hz.fwd_rs1_sel, hz.fwd_rs2_sel};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [REG_AW-1:0] rs1, input logic u1,
                            input logic [REG_AW-1:0] rs2, input logic u2, input logic [REG_AW-1:0] rd,
                            input logic wb, input logic ld, input logic mc);
        hz.id_valid    = v;
        hz.id_rs1      = rs1;
        hz.id_rs1_used = u1;
        hz.id_rs2      = rs2;
        hz.id_rs2_used = u2;
        hz.id_rd       = rd;
        hz.id_wb_en    = wb;
        hz.id_is_load  = ld;
        hz.id_is_mc    = mc;
    endtask

    task automatic drive_nop();
        drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        drive_nop();
        repeat (DEPTH) step();
    endtask

    task automatic test_reset();
        hz.br_taken = 1'b1;
        drive_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", ctl()); end
        n_checks++; if (sels() !== 4'b0000) begin n_fail++; $display("FAIL reset_sel: got %b want 0000", sels()); end
        n_checks++; if (hz.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", hz.stall_cnt); end
        hz.br_taken = 1'b0;
        drive_nop();
    endtask

    task automatic test_alu_fwd();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL alu_prod_ctl: got %b want 0000", ctl()); end
        step();
        drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL alu_cons_ctl: got %b want 0000", ctl()); end
        step();
        n_checks++; if (sels() !== {2'd1, 2'd0}) begin n_fail++; $display("FAIL alu_fwd_sel: got %b want 0100", sels()); end
        drain();
    endtask

    task automatic test_back_to_back();
        // Two producers in flight: older one one stage further along.
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); step();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); step();
        drive_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL b2b_ctl: got %b want 0000", ctl()); end
        step();
        n_checks++; if (sels() !== {2'd2, 2'd1}) begin n_fail++; $display("FAIL b2b_two_prod_sel: got %b want 1001", sels()); end
        drain();
        // Same rd written twice: the youngest must be chosen.
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); step();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); step();
        drive_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0); step();
        n_checks++; if (sels() !== {2'd1, 2'd0}) begin n_fail++; $display("FAIL b2b_youngest_sel: got %b want 0100", sels()); end
        drain();
        // Producer already in WB when the consumer is in ID: regfile write-through covers it.
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); step();
        drive_nop(); step();
        step();
        drive_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0); step();
        n_checks++; if (sels() !== 4'b0000) begin n_fail++; $display("FAIL b2b_wb_sel: got %b want 0000", sels()); end
        drain();
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0); step();
        drive_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b1101) begin n_fail++; $display("FAIL lu_stall_ctl: got %b want 1101", ctl()); end
        step();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL lu_release_ctl: got %b want 0000", ctl()); end
        n_checks++; if (sels() !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble_sel: got %b want 0000", sels()); end
        step();
        n_checks++; if (sels() !== {2'd0, 2'd2}) begin n_fail++; $display("FAIL lu_fwd_sel: got %b want 0010", sels()); end
        n_checks++; if (hz.stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", hz.stall_cnt); end
        drain();
    endtask

    task automatic test_mc();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0); step();
        drive_id(1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1); step();
        drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        hz.ex_mc_done = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            n_checks++; if (ctl() !== 4'b1100) begin n_fail++; $display("FAIL mc_busy_ctl[%0d]: got %b want 1100", c, ctl()); end
            if (c == 4) begin
                n_checks++; if (sels() !== {2'd0, 2'd1}) begin n_fail++; $display("FAIL mc_hold_sel: got %b want 0001", sels()); end
            end
            step();
        end
        hz.ex_mc_done = 1'b1;
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL mc_done_ctl: got %b want 0000", ctl()); end
        step();
        hz.ex_mc_done = 1'b0;
        n_checks++; if (sels() !== {2'd1, 2'd0}) begin n_fail++; $display("FAIL mc_fwd_sel: got %b want 0100", sels()); end
        n_checks++; if (hz.stall_cnt !== 32'd5) begin n_fail++; $display("FAIL mc_cnt: got %0d want 5", hz.stall_cnt); end
        drain();
    endtask

    task automatic test_flush();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0); step();
        drive_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        hz.br_taken = 1'b1;
        settle();
        n_checks++; if (ctl() !== 4'b0011) begin n_fail++; $display("FAIL flush_ctl: got %b want 0011", ctl()); end
        step();
        hz.br_taken = 1'b0;
        drive_id(1'b1, 5'd9, 1'b1, 5'd6, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL flush_next_ctl: got %b want 0000", ctl()); end
        step();
        n_checks++; if (sels() !== {2'd0, 2'd2}) begin n_fail++; $display("FAIL flush_squash_sel: got %b want 0010", sels()); end
        n_checks++; if (hz.stall_cnt !== 32'd5) begin n_fail++; $display("FAIL flush_cnt: got %0d want 5", hz.stall_cnt); end
        drain();
    endtask

    task automatic test_x0_unused_invalid();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); step();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL x0_ctl: got %b want 0000", ctl()); end
        step();
        n_checks++; if (sels() !== 4'b0000) begin n_fail++; $display("FAIL x0_sel: got %b want 0000", sels()); end
        drain();
        // Load to x0 never creates a load-use stall.
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); step();
        drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd18, 1'b1, 1'b0, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL x0_load_ctl: got %b want 0000", ctl()); end
        drain();
        // Matching address on an unread source is not a dependency.
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0); step();
        drive_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 5'd19, 1'b1, 1'b0, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL unused_src_ctl: got %b want 0000", ctl()); end
        step();
        n_checks++; if (sels() !== 4'b0000) begin n_fail++; $display("FAIL unused_src_sel: got %b want 0000", sels()); end
        drain();
        // Empty ID slot never stalls even if its fields look dependent.
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0); step();
        drive_id(1'b0, 5'd15, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b0, 1'b0);
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL id_invalid_ctl: got %b want 0000", ctl()); end
        step();
        n_checks++; if (sels() !== 4'b0000) begin n_fail++; $display("FAIL id_invalid_sel: got %b want 0000", sels()); end
        n_checks++; if (hz.stall_cnt !== 32'd5) begin n_fail++; $display("FAIL x0_cnt: got %0d want 5", hz.stall_cnt); end
        drain();
    endtask

    task automatic test_reset_mid_mc();
        drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1); step();
        drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0);
        hz.ex_mc_done = 1'b0;
        step();
        step();
        n_checks++; if (ctl() !== 4'b1100) begin n_fail++; $display("FAIL rmc_busy_ctl: got %b want 1100", ctl()); end
        rst = 1'b0;
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL rmc_hold_ctl: got %b want 0000", ctl()); end
        step();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL rmc_after_edge_ctl: got %b want 0000", ctl()); end
        n_checks++; if (sels() !== 4'b0000) begin n_fail++; $display("FAIL rmc_after_edge_sel: got %b want 0000", sels()); end
        n_checks++; if (hz.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rmc_after_edge_cnt: got %0d want 0", hz.stall_cnt); end
        rst = 1'b1;
        settle();
        n_checks++; if (ctl() !== 4'b0000) begin n_fail++; $display("FAIL rmc_release_ctl: got %b want 0000", ctl()); end
        step();
        n_checks++; if (sels() !== 4'b0000) begin n_fail++; $display("FAIL rmc_release_sel: got %b want 0000", sels()); end
        n_checks++; if (hz.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rmc_release_cnt: got %0d want 0", hz.stall_cnt); end
        drain();
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        hz.ex_mc_done = 1'b0;
        hz.br_taken   = 1'b0;
        drive_nop();
        repeat (2) step();
        test_reset();
        rst = 1'b1;
        test_alu_fwd();
        test_back_to_back();
        test_load_use();
        test_mc();
        test_flush();
        test_x0_unused_invalid();
        test_reset_mid_mc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register address width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked post-ID stages E[0]=EX .. E[DEPTH-1]=WB; legal range 3..6.
REQ-003 SHALL have parameter SEL_W, default $clog2(DEPTH), forward-select width.
REQ-004 Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-low.
- rst  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source addresses.
- id_rs1_used, id_rs2_used  in  1  source actually read.
- id_rd  in  REG_AW  destination address.
- id_wb_en  in  1  instruction writes rd.
- id_is_load  in  1  load; data ready from E[2].
- id_is_mc  in  1  multi-cycle EX op (mul/div).
- ex_mc_done  in  1  multi-cycle unit finishes this cycle.
- br_taken  in  1  branch/jump in EX redirects PC.
- stall_if, stall_id  out  1  hold PC and IF/ID register.
- flush_id  out  1  squash IF/ID contents.
- bubble_ex  out  1  load a NOP into ID/EX.
- fwd_rs1_sel, fwd_rs2_sel  out  SEL_W  registered operand select in EX: 0 = ID/EX register data, k = result of stage E[k].
- stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-005 Scoreboard entry SHALL be {valid, rd, is_load, is_mc}; an entry SHALL be valid only if id_wb_en=1 and rd!=0 at issue.
REQ-006 Normal cycle (no hold): E[k+1]<=E[k] for all k; E[0]<=ID instruction if issued, else invalid; E[DEPTH-1] is discarded.
REQ-007 Readiness: an ALU producer SHALL be forwardable from E[1] onward; a load producer from E[2] onward.
REQ-008 Load-use: if E[0].is_load and E[0].rd matches a used ID source, stall_if=stall_id=bubble_ex=1 for exactly one cycle.
REQ-009 Forward select: for each used source, search E[0..DEPTH-2] youngest first; on the first rd match at E[j], the select SHALL be registered as j+1. With no match, the select SHALL be 0.
REQ-010 A producer in E[DEPTH-1] at ID time is covered by regfile write-through and SHALL NOT produce a select.
REQ-011 Address 0 SHALL never match.
REQ-012 Multi-cycle ops SHALL use two states, IDLE and MC_BUSY.
- IDLE->MC_BUSY: the issued E[0] instruction has is_mc=1 and ex_mc_done=0 in its first EX cycle.
- MC_BUSY->IDLE: ex_mc_done=1.
REQ-013 In MC_BUSY, E[0] and the fwd selects SHALL hold, E[1] SHALL receive invalid, E[2..] SHALL shift, and stall_if=stall_id=1 with bubble_ex=0.
REQ-014 In the ex_mc_done cycle, E[0] SHALL advance normally and the ID instruction SHALL issue unless another hazard applies.
REQ-015 Flush: br_taken=1 SHALL assert flush_id=1 and bubble_ex=1 and SHALL NOT enter the ID instruction into E[0]; flush overrides load-use stall (stall_* =0 that cycle).
REQ-016 br_taken during MC_BUSY is a protocol violation; the bench SHALL assert it never occurs.
REQ-017 With id_valid=0, no stall SHALL be raised and E[0] SHALL load invalid.
REQ-018 stall_cnt SHALL increment in each cycle stall_id=1 and saturate at 0xFFFF_FFFF.
REQ-019 stall_*, flush_id and bubble_ex SHALL be combinational from current state and inputs; fwd selects and stall_cnt SHALL be registered.

Reset
REQ-020 rst=0 at a rising clk edge SHALL invalidate all entries, set state IDLE, clear fwd selects and stall_cnt; all outputs SHALL be 0 while rst=0.
REQ-021 Reset during MC_BUSY SHALL abort to IDLE with no residual stall.

Structure
REQ-022 Entry struct, state enum and DEPTH/REG_AW defaults SHALL live in shared package cpu_pkg.
REQ-023 The scoreboard shift/hold register SHALL be sub-module hz_scoreboard; hazard and select logic SHALL stay in pipe_hazard_ctrl.

Verification
REQ-024 The bench SHALL cover these directed scenarios (DEPTH=3):
- ALU x5 then dependent ALU rs1=x5 -> no stall, fwd_rs1_sel=1 in the consumer's EX.
- load x6 then dependent ALU rs2=x6 -> one stall cycle; bubble_ex=1; then fwd_rs2_sel=2; stall_cnt=1.
- mul x7 with done after 4 cycles, next instruction using x7 -> stall_id high 4 cycles, then fwd_rs1_sel=1.
- br_taken with a load-use pending -> flush_id=1, bubble_ex=1, stall_id=0, squashed rd absent from scoreboard.
- Producer rd=x0 then consumer rs1=x0 -> select 0, no stall.
- rst=0 asserted mid-MC_BUSY -> next cycle all outputs 0, state IDLE.
